alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 98 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command front-end that serialises operations into the accumulator ALU
module alu_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_use_acc,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [2:0] alu_in_selector,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [6:0] alu_out_selector,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;
    stateT state;
    logic [19:0] fifoMem [DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic [19:0] head;
    logic [CW-1:0] waitCnt;
    logic empty, full, push, pop, illegal;
    assign head      = fifoMem[rdPtr[AW-1:0]];
    assign empty     = wrPtr == rdPtr;
    assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = state == IDLE && !empty;
    assign busy      = state != IDLE || !empty;
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr[AW-1:0]] <= {cmd_op, cmd_use_acc, cmd_a, cmd_b};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wrPtr            <= '0;
            rdPtr            <= '0;
            waitCnt          <= '0;
            illegal          <= 1'b0;
            alu_in_selector  <= 3'b001;
            alu_num1         <= '0;
            alu_num2         <= '0;
            alu_out_selector <= '0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_error        <= 1'b0;
        end else begin
            alu_in_selector <= 3'b100;
            if (push) wrPtr <= wrPtr + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    rdPtr   <= rdPtr + 1'b1;
                    illegal <= &head[19:17];
                    state   <= ISSUE;
                    if (!(&head[19:17])) begin
                        alu_in_selector  <= head[16] ? 3'b100 : 3'b010;
                        alu_num1         <= head[15:8];
                        alu_num2         <= head[7:0];
                        alu_out_selector <= 7'b1000000 >> head[19:17];
                    end
                end
                // An illegal op spends its issue slot with the ALU left untouched
                ISSUE: begin
                    waitCnt <= CW'(ALU_LATENCY - 1);
                    state   <= illegal ? RESP : WAIT;
                    if (illegal) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                end
                WAIT: if (waitCnt == '0) begin
                    rsp_data  <= alu_result;
                    rsp_error <= alu_overflow;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else waitCnt <= waitCnt - 1'b1;
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with an accumulator ALU model and an in-order response scoreboard
module tb_alu_cmd_sequencer;
    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_use_acc = 1'b0, rsp_ready = 1'b0, alu_overflow = 1'b0;
    logic cmd_ready, rsp_valid, rsp_error, busy;
    logic [2:0] cmd_op = '0, alu_in_selector;
    logic [7:0] cmd_a = '0, cmd_b = '0, alu_result = '0, alu_num1, alu_num2, rsp_data;
    logic [6:0] alu_out_selector;
    logic [7:0] mAcc = '0, expAcc = '0;
    logic mLoad = 1'b0;
    logic [8:0] expQ[$];
    logic [8:0] got, want;
    int nAssert = 0, nFail = 0;

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_in_selector(alu_in_selector),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_selector(alu_out_selector),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] aluFn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'b0, a} * {8'b0, b};
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, ~a};
            3'd3: return {1'b0, a ^ b};
            3'd4: return {1'b0, a} + {1'b0, b};
            3'd5: return {a < b, a - b};
            3'd6: return {|p[15:8], p[7:0]};
            default: return 9'h100;
        endcase
    endfunction

    function automatic logic [2:0] selOp(input logic [6:0] s);
        for (int i = 0; i < 7; i++) if (s[6-i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [8:0] expectRsp(input logic [2:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = aluFn(op, ua ? expAcc : a, b);
        if (!r[8]) expAcc = r[7:0];
        return r;
    endfunction

    // ALU model: result frozen after a load until the response is consumed; accumulator commits error-free results
    always @(posedge clk) begin
        if (alu_in_selector == 3'b001) begin
            mAcc <= '0;
            mLoad <= 1'b0;
            {alu_overflow, alu_result} <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (!rsp_error) mAcc <= rsp_data;
                mLoad <= 1'b0;
            end else if (alu_in_selector == 3'b010) mLoad <= 1'b1;
            if (!(mLoad && alu_in_selector != 3'b010))
                {alu_overflow, alu_result} <= aluFn(selOp(alu_out_selector),
                    alu_in_selector == 3'b010 ? alu_num1 : mAcc, alu_num2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            check("rsp_pending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                got = {rsp_error, rsp_data};
                check("rsp_scoreboard", 32'(got), 32'(want));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_use_acc = ua;
        cmd_a = a;
        cmd_b = b;
        expQ.push_back(expectRsp(op, ua, a, b));
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_accept", 32'(n < 100), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_sel", 32'(alu_in_selector), 32'b001);
        check("rst_nums", 32'({alu_num1, alu_num2}), 32'd0);
        check("rst_out_sel", 32'(alu_out_selector), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_sel", 32'(alu_in_selector), 32'b100);
        // single ADD, latency and issue fields
        rsp_ready = 1'b1;
        push(3'd4, 1'b0, 8'h12, 8'h34);
        tick();
        check("add_issue_in_sel", 32'(alu_in_selector), 32'b010);
        check("add_issue_out_sel", 32'(alu_out_selector), 32'b0000100);
        check("add_issue_nums", 32'({alu_num1, alu_num2}), 32'h1234);
        tick();
        check("add_wait_in_sel", 32'(alu_in_selector), 32'b100);
        check("add_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp", 32'({rsp_error, rsp_data}), 32'h046);
        waitDrain("add_drain");
        // chaining through the accumulator
        push(3'd4, 1'b0, 8'd5, 8'd3);
        push(3'd6, 1'b1, 8'hAA, 8'd4);
        repeat (4) tick();
        check("chain_issue_in_sel", 32'(alu_in_selector), 32'b100);
        check("chain_issue_out_sel", 32'(alu_out_selector), 32'b0000001);
        check("chain_issue_nums", 32'({alu_num1, alu_num2}), 32'hAA04);
        waitDrain("chain_drain");
        // overflow then clean AND
        push(3'd6, 1'b0, 8'h20, 8'h10);
        push(3'd0, 1'b0, 8'hF0, 8'h3C);
        waitDrain("ovf_drain");
        // illegal op
        push(3'd7, 1'b0, 8'h55, 8'h66);
        tick();
        check("ill_t1_valid", 32'(rsp_valid), 32'd0);
        check("ill_t1_in_sel", 32'(alu_in_selector), 32'b100);
        check("ill_t1_out_sel", 32'(alu_out_selector), 32'b1000000);
        tick();
        check("ill_t2_valid", 32'(rsp_valid), 32'd1);
        check("ill_t2_rsp", 32'({rsp_error, rsp_data}), 32'h100);
        check("ill_t2_out_sel", 32'(alu_out_selector), 32'b1000000);
        waitDrain("ill_drain");
        // back-pressure: 1 in flight + DEPTH queued
        rsp_ready = 1'b0;
        push(3'd4, 1'b0, 8'h01, 8'h01);
        push(3'd1, 1'b0, 8'h0F, 8'hF0);
        push(3'd2, 1'b0, 8'h55, 8'h00);
        push(3'd3, 1'b0, 8'h0F, 8'h01);
        push(3'd5, 1'b0, 8'h03, 8'h05);
        check("bp_full", 32'(cmd_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_hold0", 32'({rsp_valid, rsp_error, rsp_data}), 32'h202);
        tick();
        check("bp_hold1", 32'({rsp_valid, rsp_error, rsp_data}), 32'h202);
        check("bp_still_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        push(3'd4, 1'b1, 8'h00, 8'h02);
        waitDrain("bp_drain");
        // reset during WAIT discards in-flight and queued commands
        push(3'd4, 1'b0, 8'h01, 8'h02);
        push(3'd1, 1'b0, 8'h10, 8'h01);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_in_sel", 32'(alu_in_selector), 32'b001);
        check("mid_rst_empty", 32'({cmd_ready, busy}), 32'b10);
        check("mid_rst_out_sel", 32'(alu_out_selector), 32'd0);
        expQ.delete();
        expAcc = '0;
        tick();
        rst = 1'b0;
        tick();
        push(3'd4, 1'b0, 8'h07, 8'h08);
        waitDrain("post_rst_drain");
        check("final_idle", 32'({busy, rsp_valid}), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
